// File: rtl/sub_bytes_stream.sv
// AES SubBytes / InvSubBytes stage: per-byte S-box lanes feeding an elastic register pipeline
// with valid/ready on both sides and a completed-word counter.

module sub_bytes_lane #(
  parameter int SUPPORT_INV = 1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = gmul(x, x);
    r = s;
    for (int i = 2; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] i;
    i = ginv(b);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  always_comb begin
    dout = ((SUPPORT_INV != 0) && inv) ? inv_sbox(din) : fwd_sbox(din);
  end
endmodule

module sub_bytes_stream #(
  parameter int NUM_BYTES   = 16,
  parameter int PIPE_STAGES = 2,
  parameter int SUPPORT_INV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   out_inv,
  output logic                   busy,
  output logic [31:0]            word_count
);
  localparam int W    = 8 * NUM_BYTES;
  localparam int LAST = PIPE_STAGES - 1;

  logic [W-1:0] sub_data;

  genvar g;
  generate
    for (g = 0; g < NUM_BYTES; g++) begin : g_lane
      sub_bytes_lane #(.SUPPORT_INV(SUPPORT_INV)) u_lane (
        .din  (in_data[8*g +: 8]),
        .inv  (in_inv),
        .dout (sub_data[8*g +: 8])
      );
    end
  endgenerate

  logic [PIPE_STAGES-1:0]        vld_pipe_q, vld_pipe_d, ld;
  logic [PIPE_STAGES-1:0][W-1:0] data_q, data_d;
  logic [PIPE_STAGES-1:0]        inv_q, inv_d;
  logic                          rdy_q, rdy_d;
  logic [31:0]                   word_count_q, word_count_d;

  // A stage may load when it is empty or its word is leaving; this ripples back from out_ready.
  always_comb begin : ld_chain
    logic nxt;
    nxt = out_ready;
    ld  = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld_pipe_q[k] || nxt;
      nxt   = ld[k];
    end
  end

  // rdy_q keeps in_ready low throughout reset and raises it on the first edge afterwards.
  assign in_ready   = rdy_q && ld[0];
  assign out_valid  = vld_pipe_q[LAST];
  assign out_data   = data_q[LAST];
  assign out_inv    = inv_q[LAST];
  assign busy       = |vld_pipe_q;
  assign word_count = word_count_q;

  always_comb begin
    vld_pipe_d   = vld_pipe_q;
    data_d       = data_q;
    inv_d        = inv_q;
    rdy_d        = 1'b1;
    word_count_d = word_count_q + 32'(out_valid && out_ready);
    if (ld[0]) begin
      vld_pipe_d[0] = in_valid && in_ready;
      if (in_valid && in_ready) begin
        data_d[0] = sub_data;
        inv_d[0]  = (SUPPORT_INV != 0) && in_inv;
      end
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (ld[k]) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        if (vld_pipe_q[k-1]) begin
          data_d[k] = data_q[k-1];
          inv_d[k]  = inv_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q   <= '0;
      data_q       <= '0;
      inv_q        <= '0;
      rdy_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      data_q       <= data_d;
      inv_q        <= inv_d;
      rdy_q        <= rdy_d;
      word_count_q <= word_count_d;
    end
  end
endmodule

// File: tb/tb_sub_bytes_stream.sv
// Bench for sub_bytes_stream: three instances (2, 1 and 4 stages) share stimulus; each has a
// queue scoreboard fed from the FIPS-197 S-box table, plus directed vectors and handshake corners.

module tb_sub_bytes_stream;
  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [8*NB-1:0] in_data;
  logic            in_inv;
  logic            out_ready;
  logic            irdy [3];
  logic            ovld [3];
  logic [8*NB-1:0] odat [3];
  logic            oinv [3];
  logic            obusy [3];
  logic [31:0]     wcnt [3];

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  always #5 clk = ~clk;

  sub_bytes_stream #(.NUM_BYTES(NB), .PIPE_STAGES(2), .SUPPORT_INV(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .in_inv(in_inv), .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]),
    .out_inv(oinv[0]), .busy(obusy[0]), .word_count(wcnt[0]));
  sub_bytes_stream #(.NUM_BYTES(NB), .PIPE_STAGES(1), .SUPPORT_INV(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .in_inv(in_inv), .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]),
    .out_inv(oinv[1]), .busy(obusy[1]), .word_count(wcnt[1]));
  sub_bytes_stream #(.NUM_BYTES(NB), .PIPE_STAGES(4), .SUPPORT_INV(1)) u_p4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
    .in_inv(in_inv), .out_valid(ovld[2]), .out_ready(out_ready), .out_data(odat[2]),
    .out_inv(oinv[2]), .busy(obusy[2]), .word_count(wcnt[2]));

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  logic [7:0] isbox [256];

  function automatic logic [8*NB-1:0] model(input logic [8*NB-1:0] d, input logic inv);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = inv ? isbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [8*NB-1:0] d; logic inv; } word_t;
  word_t expq [3][$];
  word_t sb_w;

  // Scoreboard: handshakes sampled mid-cycle, so they describe the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) expq[k].delete();
      n_out = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ovld[k] && out_ready) begin
          if (expq[k].size() == 0) chk($sformatf("sb%0d_unexpected", k), 1, 0);
          else begin
            sb_w = expq[k].pop_front();
            chk($sformatf("sb%0d_data", k), odat[k], sb_w.d);
            chk($sformatf("sb%0d_inv", k), oinv[k], sb_w.inv);
          end
          if (k == 0) n_out++;
        end
        if (in_valid && irdy[k]) expq[k].push_back({model(in_data, in_inv), in_inv});
      end
    end
  end

  typedef struct { logic [8*NB-1:0] din; logic inv; logic [8*NB-1:0] dout; } vec_t;
  vec_t vecs [6];

  task automatic send(input logic [8*NB-1:0] d, input logic inv);
    logic acc;
    int   t;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge clk); acc = irdy[0];
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1; in_valid = 1'b0;
    t = 0;
    while ((obusy[0] || obusy[1] || obusy[2]) && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk($sformatf("drain%0d_left", k), expq[k].size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [8*NB-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, bad, held_inv;
    logic [8*NB-1:0] held;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[2] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
    vecs[3] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};
    vecs[4] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};
    vecs[5] = '{{16{8'hed}}, 1'b1, {16{8'h53}}};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", ovld[0], 0);
    chk("rst_out_data", odat[0], 0);
    chk("rst_out_inv", oinv[0], 0);
    chk("rst_busy", obusy[0], 0);
    chk("rst_in_ready", irdy[0], 0);
    chk("rst_word_count", wcnt[0], 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rel_in_ready_before_edge", irdy[0], 0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", irdy[0], 1);

    // Directed vectors with latency measurement.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].din, vecs[v].inv);
      lat = 1;
      while (!ovld[0] && lat < 10) begin @(posedge clk); #1; lat++; end
      chk($sformatf("vec%0d_latency", v), lat, 2);
      chk($sformatf("vec%0d_data", v), odat[0], vecs[v].dout);
      chk($sformatf("vec%0d_inv", v), oinv[0], vecs[v].inv);
    end
    drain();

    // 20-word stream, alternating mode, full throughput.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = rnd(); in_inv = i[0];
      @(negedge clk); if (!irdy[0]) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_in_ready_drops", bad, 0);
    repeat (2) @(posedge clk); #1;
    chk("stream_word_count", wcnt[0], 20);
    chk("stream_empty", ovld[0], 0);
    drain();

    // Backpressure: fill, hold, then pass-through and drain.
    out_ready = 1'b0; in_valid = 1'b1; in_data = rnd(); in_inv = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); lat = int'(irdy[0]); acc += lat;
      @(posedge clk); #1;
      if (lat != 0) begin in_data = rnd(); in_inv = $urandom_range(0, 1); end
    end
    chk("stall_accepts", acc, 2);
    @(negedge clk);
    chk("stall_in_ready", irdy[0], 0);
    chk("stall_busy", obusy[0], 1);
    held = odat[0]; held_inv = int'(oinv[0]);
    repeat (3) @(posedge clk); #1;
    chk("stall_data_stable", odat[0], held);
    chk("stall_inv_stable", oinv[0], held_inv[0]);
    chk("stall_out_valid", ovld[0], 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_passthru_in_ready", irdy[0], 1);
    @(posedge clk); #1;
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(rnd(), 1'b0);
    send(rnd(), 1'b1);
    #3 rst = 1'b0; #1;
    chk("midrst_out_valid", ovld[0], 0);
    chk("midrst_busy", obusy[0], 0);
    chk("midrst_word_count", wcnt[0], 0);
    chk("midrst_in_ready", irdy[0], 0);
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (ovld[0] || ovld[1] || ovld[2]) bad++; end
    chk("midrst_stale_outputs", bad, 0);

    // Exhaustive byte sweep, both modes, all three pipeline depths.
    in_valid = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 256; v++) begin
        in_data = {16{8'(v)}}; in_inv = m[0];
        @(posedge clk); #1;
      end
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rnd(); in_inv = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();
    chk("rand_word_count", wcnt[0], n_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
